// File: rtl/tlb_sv32.sv
// Fully-associative Sv32 TLB in front of the page-table walker.
// A hit or a bypass answers in the same cycle; a miss holds a walk request until the MMU fills or faults.
module tlb_sv32 #(
   parameter int ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tlb_on,
   input  logic        new_request,
   input  logic [31:0] virtual_address,
   input  logic        rnw,
   input  logic        execute,
   input  logic [1:0]  privilege,
   input  logic        sum,
   input  logic        mxr,
   input  logic        abort_request,
   input  logic        flush,
   output logic        done,
   output logic        is_fault,
   output logic [31:0] physical_address,
   output logic        flush_complete,
   output logic        mmu_request,
   output logic [31:0] mmu_virtual_address,
   output logic        mmu_rnw,
   output logic        mmu_execute,
   input  logic        mmu_write_entry,
   input  logic        mmu_is_fault,
   input  logic        mmu_superpage,
   input  logic [7:0]  mmu_perms,
   input  logic [19:0] mmu_upper_physical_address
);

   localparam int IW = $clog2(ENTRIES);

   typedef enum logic [1:0] {IDLE, MISS, REPLAY, FAULT} state_t;

   // perms drops the global bit: {d,a,u,x,w,r,v}
   typedef struct packed {
      logic        superpage;
      logic [19:0] tag;
      logic [19:0] ppn;
      logic [6:0]  perms;
   } entry_t;

   state_t             state_q, state_d;
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic               flush_complete_q, flush_complete_d;
   logic [31:0]        miss_va_q, miss_va_d;
   logic               miss_rnw_q, miss_rnw_d;
   logic               miss_exe_q, miss_exe_d;
   entry_t             entry_q [ENTRIES];
   entry_t             entry_d [ENTRIES];

   logic               unused_global;
   assign unused_global = mmu_perms[5];

   logic    hit;
   entry_t  hit_entry;
   logic    [IW-1:0] victim;
   logic    found_free;

   // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      hit       = 1'b0;
      hit_entry = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && entry_q[i].tag[19:10] == virtual_address[31:22] &&
             (entry_q[i].superpage || entry_q[i].tag[9:0] == virtual_address[21:12])) begin
            hit       = 1'b1;
            hit_entry = entry_q[i];
         end
      end
   end

   always_comb begin
      victim     = ptr_q;
      found_free = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!valid_q[i] && !found_free) begin
            victim     = IW'(i);
            found_free = 1'b1;
         end
      end
   end

   logic p_v, p_r, p_w, p_x, p_u, p_a, p_d;
   logic access_ok, priv_ok, perm_ok;
   assign {p_d, p_a, p_u, p_x, p_w, p_r, p_v} = hit_entry.perms;
   assign access_ok = execute ? p_x : (rnw ? (p_r | (mxr & p_x)) : (p_w & p_d));
   assign priv_ok   = (privilege == 2'd0) ? p_u : (~p_u | (sum & ~execute));
   assign perm_ok   = p_v & p_a & (~p_w | p_r) & access_ok & priv_ok;

   assign physical_address = !tlb_on ? virtual_address :
      {hit_entry.ppn[19:10], hit_entry.superpage ? virtual_address[21:12] : hit_entry.ppn[9:0],
       virtual_address[11:0]};

   logic kill, fill_en;
   assign kill = abort_request | flush;

   always_comb begin
      state_d          = state_q;
      valid_d          = valid_q;
      ptr_d            = ptr_q;
      miss_va_d        = miss_va_q;
      miss_rnw_d       = miss_rnw_q;
      miss_exe_d       = miss_exe_q;
      flush_complete_d = flush;
      done             = 1'b0;
      is_fault         = 1'b0;
      mmu_request      = 1'b0;
      fill_en          = 1'b0;
      case (state_q)
         IDLE: begin
            if (new_request && !kill) begin
               if (!tlb_on) begin
                  done = 1'b1;
               end else if (hit) begin
                  done     = 1'b1;
                  is_fault = ~perm_ok;
               end else begin
                  miss_va_d  = virtual_address;
                  miss_rnw_d = rnw;
                  miss_exe_d = execute;
                  state_d    = MISS;
               end
            end
         end
         MISS: begin
            mmu_request = ~kill;
            if (mmu_write_entry) begin
               fill_en = ~kill;
               state_d = REPLAY;
            end else if (mmu_is_fault) begin
               state_d = FAULT;
            end
         end
         REPLAY: state_d = IDLE;
         FAULT: begin
            done     = ~kill;
            is_fault = ~kill;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
      if (fill_en) begin
         valid_d[victim] = 1'b1;
         ptr_d           = ptr_q + IW'(1);
      end
      if (flush) valid_d = '0;
   end

   always_comb begin
      entry_d = entry_q;
      if (fill_en) begin
         entry_d[victim].superpage = mmu_superpage;
         entry_d[victim].tag       = miss_va_q[31:12];
         entry_d[victim].ppn       = mmu_upper_physical_address;
         entry_d[victim].perms     = {mmu_perms[7:6], mmu_perms[4:0]};
      end
   end

   // NOTE: sequential state is assigned only with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         valid_q          <= '0;
         ptr_q            <= '0;
         flush_complete_q <= 1'b0;
         miss_va_q        <= '0;
         miss_rnw_q       <= 1'b0;
         miss_exe_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         valid_q          <= valid_d;
         ptr_q            <= ptr_d;
         flush_complete_q <= flush_complete_d;
         miss_va_q        <= miss_va_d;
         miss_rnw_q       <= miss_rnw_d;
         miss_exe_q       <= miss_exe_d;
      end
   end

   // NOTE: entry payload is not reset; the valid bits alone decide whether it is ever looked at.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   assign flush_complete      = flush_complete_q;
   assign mmu_virtual_address = miss_va_q;
   assign mmu_rnw             = miss_rnw_q;
   assign mmu_execute         = miss_exe_q;

endmodule

// File: tb/tb_tlb_sv32.sv
// Self-checking bench for tlb_sv32: directed scenarios followed by random traffic
// compared against a page-level reference model of the TLB contents.
module tb_tlb_sv32;

   localparam int ENTRIES = 8;

   logic        clk = 1'b0;
   logic        rst, tlb_on, new_request, rnw, execute, sum, mxr, abort_request, flush;
   logic [31:0] virtual_address;
   logic [1:0]  privilege;
   logic        done, is_fault, flush_complete, mmu_request, mmu_rnw, mmu_execute;
   logic [31:0] physical_address, mmu_virtual_address;
   logic        mmu_write_entry, mmu_is_fault, mmu_superpage;
   logic [7:0]  mmu_perms;
   logic [19:0] mmu_upper_physical_address;

   always #5 clk = ~clk;

   tlb_sv32 #(.ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst(rst), .tlb_on(tlb_on), .new_request(new_request),
      .virtual_address(virtual_address), .rnw(rnw), .execute(execute),
      .privilege(privilege), .sum(sum), .mxr(mxr), .abort_request(abort_request),
      .flush(flush), .done(done), .is_fault(is_fault), .physical_address(physical_address),
      .flush_complete(flush_complete), .mmu_request(mmu_request),
      .mmu_virtual_address(mmu_virtual_address), .mmu_rnw(mmu_rnw), .mmu_execute(mmu_execute),
      .mmu_write_entry(mmu_write_entry), .mmu_is_fault(mmu_is_fault),
      .mmu_superpage(mmu_superpage), .mmu_perms(mmu_perms),
      .mmu_upper_physical_address(mmu_upper_physical_address)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: a list of cached pages plus the replacement pointer.
   bit          m_valid [ENTRIES];
   bit          m_super [ENTRIES];
   logic [19:0] m_vpn   [ENTRIES];
   logic [19:0] m_ppn   [ENTRIES];
   logic [7:0]  m_perms [ENTRIES];
   int          m_ptr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_flush();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
   endfunction

   function automatic int m_lookup(input logic [31:0] va);
      for (int i = 0; i < ENTRIES; i++) begin
         if (m_valid[i]) begin
            if (m_super[i] && (va >> 22) == 32'(m_vpn[i] >> 10)) return i;
            if (!m_super[i] && (va >> 12) == 32'(m_vpn[i])) return i;
         end
      end
      return -1;
   endfunction

   function automatic bit m_region_used(input logic [31:0] va);
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] && (va >> 22) == 32'(m_vpn[i] >> 10)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_perm_ok(input logic [7:0] p, input bit rd, input bit ex,
                                    input logic [1:0] pr, input bit sm, input bit mx);
      bit v, r, w, x, u, a, d;
      v = p[0]; r = p[1]; w = p[2]; x = p[3]; u = p[4]; a = p[6]; d = p[7];
      if (!v || !a || (w && !r)) return 1'b0;
      if (ex) begin
         if (!x) return 1'b0;
      end else if (rd) begin
         if (!(r || (mx && x))) return 1'b0;
      end else if (!(w && d)) begin
         return 1'b0;
      end
      if (pr == 2'd0 && !u) return 1'b0;
      if (pr != 2'd0 && u && !(sm && !ex)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_pa(input int i, input logic [31:0] va);
      if (m_super[i]) return {m_ppn[i][19:10], va[21:0]};
      return {m_ppn[i], va[11:0]};
   endfunction

   function automatic void m_fill(input logic [31:0] va, input bit sp, input logic [19:0] ppn,
                                  input logic [7:0] perms);
      int slot;
      slot = m_ptr;
      for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      m_valid[slot] = 1'b1;
      m_super[slot] = sp;
      m_vpn[slot]   = va[31:12];
      m_ppn[slot]   = ppn;
      m_perms[slot] = perms;
      m_ptr = (m_ptr + 1) % ENTRIES;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_flush();
      m_ptr = 0;
      settle();
      check("reset_done", done, 0);
      check("reset_is_fault", is_fault, 0);
      check("reset_flush_complete", flush_complete, 0);
      check("reset_mmu_request", mmu_request, 0);
   endtask

   // One translation; on a miss the bench plays the MMU, filling or faulting after wait_cycles.
   task automatic access(input string tag, input logic [31:0] va, input bit rd, input bit ex,
                         input logic [1:0] pr, input bit sm, input bit mx,
                         input bit mf, input bit sp, input logic [19:0] fppn,
                         input logic [7:0] fperms, input int wait_cycles,
                         output bit hit_now, output bit got_fault, output logic [31:0] got_pa);
      int  idx;
      bit  ok;
      tick();
      new_request = 1'b1; virtual_address = va; rnw = rd; execute = ex;
      privilege = pr; sum = sm; mxr = mx;
      settle();
      idx       = m_lookup(va);
      hit_now   = done;
      got_fault = is_fault;
      got_pa    = physical_address;
      check({tag, "_idle_mmu_request"}, mmu_request, 0);
      if (idx >= 0) begin
         ok = m_perm_ok(m_perms[idx], rd, ex, pr, sm, mx);
         check({tag, "_hit_done"}, done, 1);
         check({tag, "_hit_fault"}, is_fault, !ok);
         if (ok) check({tag, "_hit_pa"}, physical_address, m_pa(idx, va));
      end else begin
         check({tag, "_miss_done"}, done, 0);
         tick();
         settle();
         check({tag, "_mmu_request"}, mmu_request, 1);
         check({tag, "_mmu_va"}, mmu_virtual_address, va);
         check({tag, "_mmu_type"}, {mmu_rnw, mmu_execute}, {rd, ex});
         for (int c = 0; c < wait_cycles; c++) begin
            tick();
            settle();
            check({tag, "_wait_request"}, mmu_request, 1);
            check({tag, "_wait_done"}, done, 0);
         end
         tick();
         if (mf) begin
            mmu_is_fault = 1'b1;
         end else begin
            mmu_write_entry = 1'b1; mmu_superpage = sp;
            mmu_upper_physical_address = fppn; mmu_perms = fperms;
         end
         settle();
         check({tag, "_fill_request"}, mmu_request, 1);
         check({tag, "_fill_done"}, done, 0);
         tick();
         mmu_write_entry = 1'b0; mmu_is_fault = 1'b0;
         settle();
         if (mf) begin
            got_fault = is_fault;
            check({tag, "_mmu_fault_done"}, done, 1);
            check({tag, "_mmu_fault_flag"}, is_fault, 1);
         end else begin
            m_fill(va, sp, fppn, fperms);
            check({tag, "_replay_done"}, done, 0);
            check({tag, "_replay_request"}, mmu_request, 0);
            tick();
            settle();
            idx       = m_lookup(va);
            ok        = m_perm_ok(m_perms[idx], rd, ex, pr, sm, mx);
            got_fault = is_fault;
            got_pa    = physical_address;
            check({tag, "_after_fill_done"}, done, 1);
            check({tag, "_after_fill_fault"}, is_fault, !ok);
            if (ok) check({tag, "_after_fill_pa"}, physical_address, m_pa(idx, va));
         end
      end
      tick();
      new_request = 1'b0;
   endtask

   bit          h, f, rd_r, ex_r, sm_r, mx_r, mf_r, sp_r;
   logic [31:0] pa, va_r;
   logic [19:0] ppn_r;
   logic [7:0]  perm_r;
   logic [1:0]  pr_r;
   logic [9:0]  region_r, page_r;
   logic [11:0] off_r;

   initial begin
      rst = 1'b1; tlb_on = 1'b1; new_request = 1'b0; virtual_address = '0;
      rnw = 1'b1; execute = 1'b0; privilege = 2'd1; sum = 1'b0; mxr = 1'b0;
      abort_request = 1'b0; flush = 1'b0; mmu_write_entry = 1'b0; mmu_is_fault = 1'b0;
      mmu_superpage = 1'b0; mmu_perms = '0; mmu_upper_physical_address = '0;
      do_reset();

      // Translation disabled: identity map in the same cycle.
      tick();
      tlb_on = 1'b0; new_request = 1'b1; virtual_address = 32'h1234_5678;
      settle();
      check("bypass_done", done, 1);
      check("bypass_pa", physical_address, 32'h1234_5678);
      check("bypass_fault", is_fault, 0);
      check("bypass_mmu_request", mmu_request, 0);
      tick();
      new_request = 1'b0; tlb_on = 1'b1;
      settle();
      check("bypass_no_state_change", mmu_request, 0);

      // 4 KiB fill, then a same-page hit.
      access("fill4k", 32'h0040_3010, 1, 0, 2'd1, 0, 0, 0, 0, 20'h8_0123, 8'hC7, 2, h, f, pa);
      check("fill4k_was_miss", h, 0);
      check("fill4k_pa", pa, 32'h8012_3010);
      check("fill4k_fault", f, 0);
      access("hit4k", 32'h0040_3ABC, 1, 0, 2'd1, 0, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("hit4k_hit", h, 1);
      check("hit4k_pa", pa, 32'h8012_3ABC);

      // Superpage fill; another page of the same 4 MiB region hits.
      access("fillsp", 32'h0080_0000, 1, 0, 2'd1, 0, 0, 0, 1, 20'hFFC00, 8'hC7, 1, h, f, pa);
      check("fillsp_pa", pa, 32'hFFC0_0000);
      access("hitsp", 32'h008F_FFFC, 1, 0, 2'd1, 0, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("hitsp_hit", h, 1);
      check("hitsp_pa", pa, 32'hFFCF_FFFC);

      // Permission faults on hits.
      access("nod_fill", 32'h0100_0000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h00ABC, 8'h47, 0, h, f, pa);
      check("nod_read_ok", f, 0);
      access("nod_write", 32'h0100_0004, 0, 0, 2'd1, 0, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("nod_write_hit", h, 1);
      check("nod_write_fault", f, 1);
      access("umode", 32'h0040_3000, 1, 0, 2'd0, 0, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("umode_hit", h, 1);
      check("umode_fault", f, 1);
      access("sum_fill", 32'h0100_1000, 1, 0, 2'd1, 1, 0, 0, 0, 20'h00DEF, 8'hDB, 0, h, f, pa);
      check("sum_read_ok", f, 0);
      access("sum_fetch", 32'h0100_1000, 1, 1, 2'd1, 1, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("sum_fetch_hit", h, 1);
      check("sum_fetch_fault", f, 1);

      // MMU-reported fault.
      access("walk_fault", 32'h0200_0000, 1, 0, 2'd1, 0, 0, 1, 0, 20'h0, 8'h0, 1, h, f, pa);
      check("walk_fault_flag", f, 1);

      // Replacement: 8 fills from empty, a 9th evicts entry 0, pointer then sits at 1.
      do_reset();
      for (int i = 0; i < ENTRIES + 1; i++)
         access("fill_seq", 32'h1000_0000 + 32'(i) * 32'h1000, 1, 0, 2'd1, 0, 0, 0, 0,
                20'h2_0000 + 20'(i), 8'hC7, 0, h, f, pa);
      access("keep7", 32'h1000_7000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h0, 8'h0, 0, h, f, pa);
      check("keep7_hit", h, 1);
      access("evict0", 32'h1000_0000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h3_0000, 8'hC7, 0, h, f, pa);
      check("evict0_miss", h, 0);
      access("evict1", 32'h1000_1000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h3_0001, 8'hC7, 0, h, f, pa);
      check("ptr_wrapped_to_1", h, 0);

      // Abort during MISS.
      tick();
      new_request = 1'b1; virtual_address = 32'h2000_0000; rnw = 1'b1; execute = 1'b0;
      tick();
      settle();
      check("abort_pre_request", mmu_request, 1);
      tick();
      abort_request = 1'b1;
      settle();
      check("abort_request_drop", mmu_request, 0);
      check("abort_no_done", done, 0);
      tick();
      abort_request = 1'b0; new_request = 1'b0;
      settle();
      check("abort_idle_request", mmu_request, 0);
      check("abort_idle_done", done, 0);

      // Abort concurrent with a fill: nothing installed.
      tick();
      new_request = 1'b1; virtual_address = 32'h2000_0000;
      tick();
      abort_request = 1'b1; mmu_write_entry = 1'b1; mmu_superpage = 1'b0;
      mmu_upper_physical_address = 20'h1_1111; mmu_perms = 8'hC7;
      settle();
      check("abort_fill_request", mmu_request, 0);
      tick();
      abort_request = 1'b0; mmu_write_entry = 1'b0; new_request = 1'b0;
      settle();
      check("abort_fill_done", done, 0);
      access("after_abort", 32'h2000_0000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h1_2222, 8'hC7, 0, h, f, pa);
      check("after_abort_miss", h, 0);

      // Flush concurrent with a fill: flush wins.
      tick();
      new_request = 1'b1; virtual_address = 32'h3000_0000;
      tick();
      settle();
      check("flush_pre_request", mmu_request, 1);
      tick();
      flush = 1'b1; mmu_write_entry = 1'b1; mmu_upper_physical_address = 20'h4_4444;
      settle();
      check("flush_fill_done", done, 0);
      tick();
      flush = 1'b0; mmu_write_entry = 1'b0; new_request = 1'b0;
      m_flush();
      settle();
      check("flush_complete_pulse", flush_complete, 1);
      check("flush_request_drop", mmu_request, 0);
      tick();
      settle();
      check("flush_complete_once", flush_complete, 0);
      access("after_flush", 32'h3000_0000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h5_5555, 8'hC7, 0, h, f, pa);
      check("after_flush_miss", h, 0);
      access("flushed_old", 32'h2000_0000, 1, 0, 2'd1, 0, 0, 0, 0, 20'h1_2222, 8'hC7, 0, h, f, pa);
      check("flushed_old_miss", h, 0);

      // Flush with a hitting request in the same cycle: no done.
      tick();
      new_request = 1'b1; virtual_address = 32'h3000_0000; flush = 1'b1;
      settle();
      check("flush_ignores_request", done, 0);
      tick();
      flush = 1'b0; new_request = 1'b0;
      m_flush();

      // Random traffic against the model.
      for (int n = 0; n < 80; n++) begin
         region_r = 10'($urandom_range(5, 7));
         page_r   = 10'($urandom_range(0, 3) * 37);
         off_r    = 12'($urandom_range(0, 4095));
         va_r     = {region_r, page_r, off_r};
         rd_r     = 1'($urandom_range(0, 1));
         ex_r     = ($urandom_range(0, 3) == 0);
         pr_r     = 2'($urandom_range(0, 1));
         sm_r     = 1'($urandom_range(0, 1));
         mx_r     = 1'($urandom_range(0, 1));
         mf_r     = ($urandom_range(0, 5) == 0);
         sp_r     = !m_region_used(va_r) && ($urandom_range(0, 3) == 0);
         ppn_r    = 20'($urandom);
         if (sp_r) ppn_r[9:0] = va_r[21:12];
         perm_r   = 8'($urandom);
         if ($urandom_range(0, 3) != 0) perm_r = perm_r | 8'h41;
         access("rand", va_r, rd_r, ex_r, pr_r, sm_r, mx_r, mf_r, sp_r, ppn_r, perm_r,
                $urandom_range(0, 3), h, f, pa);
         if ($urandom_range(0, 14) == 0) begin
            tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            m_flush();
            settle();
            check("rand_flush_complete", flush_complete, 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
